// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and sizing helpers for the FIFO read-side stream adapter.
//   BUF_DEPTH_MIN/MAX : legal range of the adapter output buffer depth
//   DATA_WIDTH_DEF    : default stream/FIFO data width
//   ptr_width()       : bits needed for a ring-buffer pointer (0..depth-1)
//   occ_width()       : bits needed for an occupancy count (0..depth)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int BUF_DEPTH_MIN  = 2;
    localparam int BUF_DEPTH_MAX  = 8;
    localparam int DATA_WIDTH_DEF = 42;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter_if
// Bundles the FIFO read port and the downstream valid/ready stream.
//   fifo_ren_o   : FIFO read enable            (adapter -> FIFO)
//   fifo_empty_i : FIFO empty, registered       (FIFO -> adapter)
//   fifo_rdata_i : FIFO read data               (FIFO -> adapter)
//   fifo_rerr_i  : FIFO read-while-empty pulse  (FIFO -> adapter)
//   m_valid_o    : stream valid                 (adapter -> sink)
//   m_data_o     : stream data                  (adapter -> sink)
//   m_ready_i    : stream ready                 (sink -> adapter)
// Modport master is the adapter side; slave is the FIFO/sink environment.
// -----------------------------------------------------------------------------
interface fifo_rd_stream_adapter_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  fifo_ren_o;
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_rdata_i;
    logic                  fifo_rerr_i;
    logic                  m_valid_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_ready_i;

    modport master (
        output fifo_ren_o,
        input  fifo_empty_i,
        input  fifo_rdata_i,
        input  fifo_rerr_i,
        output m_valid_o,
        output m_data_o,
        input  m_ready_i
    );

    modport slave (
        input  fifo_ren_o,
        output fifo_empty_i,
        output fifo_rdata_i,
        output fifo_rerr_i,
        input  m_valid_o,
        input  m_data_o,
        output m_ready_i
    );

endinterface

// File: rtl/stream_ring_buf.sv
// -----------------------------------------------------------------------------
// stream_ring_buf
// Circular buffer of DEPTH entries (any DEPTH, pointers wrap explicitly) with
// a registered head-of-queue output.
//   clk_i, rst_an_i : clock, asynchronous active-low reset
//   i_push, i_wdata : write one entry (ignored when full unless popping)
//   i_pop           : remove the head entry (ignored when empty)
//   i_flush         : synchronous clear; overrides push and pop
//   o_occ           : number of stored entries, 0..DEPTH
//   o_head          : head entry, valid whenever o_occ != 0
//   o_ovf           : push attempted while full without a pop
// -----------------------------------------------------------------------------
module stream_ring_buf
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int  DEPTH      = 3,
    localparam int PTR_W      = ptr_width(DEPTH),
    localparam int OCC_W      = occ_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_an_i,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [OCC_W-1:0]      o_occ,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_ovf
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      w_rd_nxt;
    logic [OCC_W-1:0]      r_occ;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_full   = (r_occ == OCC_W'(DEPTH));
    assign w_pop    = i_pop && (r_occ != '0) && !i_flush;
    assign w_push   = i_push && (!w_full || w_pop) && !i_flush;
    assign o_ovf    = i_push && w_full && !w_pop && !i_flush;
    assign w_rd_nxt = next_ptr(r_rd_ptr);

    // The head register is loaded straight from the write data when the
    // incoming word becomes the head (buffer empty, or last entry leaving);
    // otherwise it advances to the next stored entry on a pop.
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_head_nxt = r_head;
        if (w_push && ((r_occ == '0) || ((r_occ == OCC_W'(1)) && w_pop))) begin
            w_head_nxt = i_wdata;
        end else if (w_pop) begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together at the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - OCC_W'(1);
            end
            r_head <= w_head_nxt;
        end
    end

    // NOTE: storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_head;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter
// Read-side consumer of the dual-clock FIFO. Issues FIFO reads only when the
// output buffer has guaranteed room (buffered + in-flight < BUF_DEPTH), so
// the read enable depends on registered state only and never on m_ready_i.
// Absorbs a 0- or 1-cycle FIFO read latency and presents a valid/ready stream.
//   clk_i, rst_an_i : read-domain clock, asynchronous active-low reset
//   bus_if          : FIFO read port + output stream (master modport)
//   flush_i         : drop buffered and in-flight words, clear err_o
//   err_o           : sticky error (FIFO read error or buffer overflow)
//   cnt_o           : count of delivered words (valid && ready), wrapping
// -----------------------------------------------------------------------------
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RDATA_REG  = 1,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_an_i,
    fifo_rd_stream_adapter_if.master bus_if,
    input  logic                     flush_i,
    output logic                     err_o,
    output logic [CNT_WIDTH-1:0]     cnt_o
);

    localparam int              OCC_W   = occ_width(BUF_DEPTH);
    localparam logic [OCC_W:0]  DEPTH_C = (OCC_W + 1)'(BUF_DEPTH);

    if ((BUF_DEPTH < BUF_DEPTH_MIN) || (BUF_DEPTH > BUF_DEPTH_MAX)) begin : g_bad_depth
        $error("fifo_rd_stream_adapter: BUF_DEPTH=%0d outside %0d..%0d",
               BUF_DEPTH, BUF_DEPTH_MIN, BUF_DEPTH_MAX);
    end

    if ((RDATA_REG != 0) && (RDATA_REG != 1)) begin : g_bad_rdata_reg
        $error("fifo_rd_stream_adapter: RDATA_REG=%0d must be 0 or 1", RDATA_REG);
    end

    logic [OCC_W-1:0]      w_occ;
    logic [OCC_W:0]        w_pending;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_infl;
    logic                  w_ren;
    logic                  w_push;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_ovf;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_cnt;

    // Words already committed to the buffer: stored plus the one in flight.
    assign w_pending = {1'b0, w_occ} + {{OCC_W{1'b0}}, w_infl};
    assign w_ren     = !bus_if.fifo_empty_i && !flush_i && (w_pending < DEPTH_C);

    if (RDATA_REG != 0) begin : g_rdata_reg
        // Read data arrives one cycle after the accepted ren; a flush in that
        // cycle discards it.
        logic r_infl;

        always_ff @(posedge clk_i or negedge rst_an_i) begin
            if (!rst_an_i) begin
                r_infl <= 1'b0;
            end else begin
                r_infl <= w_ren;
            end
        end

        assign w_infl = r_infl;
        assign w_push = r_infl && !flush_i;
    end else begin : g_rdata_comb
        // Read data is valid alongside ren, so nothing is ever in flight.
        assign w_infl = 1'b0;
        assign w_push = w_ren;
    end

    assign w_valid = (w_occ != '0);
    assign w_pop   = w_valid && bus_if.m_ready_i && !flush_i;

    stream_ring_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_ring (
        .clk_i    (clk_i),
        .rst_an_i (rst_an_i),
        .i_push   (w_push),
        .i_wdata  (bus_if.fifo_rdata_i),
        .i_pop    (w_pop),
        .i_flush  (flush_i),
        .o_occ    (w_occ),
        .o_head   (w_head),
        .o_ovf    (w_ovf)
    );

    // Flush wins over a simultaneous error so software can always clear it.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_err <= 1'b0;
        end else if (flush_i) begin
            r_err <= 1'b0;
        end else if (bus_if.fifo_rerr_i || w_ovf) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus_if.fifo_ren_o = w_ren;
    assign bus_if.m_valid_o  = w_valid;
    assign bus_if.m_data_o   = w_head;
    assign err_o             = r_err;
    assign cnt_o             = r_cnt;

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
Read-side consumer for the dual-clock gray-pointer FIFO, clocked in the FIFO read domain. Drives the FIFO ren/empty/rdata interface, absorbs its 0- or 1-cycle read-data latency, and presents a valid/ready stream downstream. A small output buffer sustains 1 word/cycle with no combinational path from m_ready_i to fifo_ren_o. Also provides a flush, a sticky read-error flag and a delivered-word counter.

Parameters:
DATA_WIDTH, 42, stream/FIFO data width
RDATA_REG, 1, FIFO read latency: 1 = rdata valid the cycle after the accepted ren; 0 = rdata valid in the same cycle
BUF_DEPTH, 3, output buffer entries; legal range 2..8; any other value triggers $error at elaboration
CNT_WIDTH, 32, width of the delivered-word counter

Ports:
clk_i  in  1  read-domain clock (same clock as the FIFO read side)
rst_an_i  in  1  asynchronous active-low reset
fifo_ren_o  out  1  FIFO read enable
fifo_empty_i  in  1  FIFO empty (registered in FIFO)
fifo_rdata_i  in  DATA_WIDTH  FIFO read data
fifo_rerr_i  in  1  FIFO read-while-empty error pulse
flush_i  in  1  synchronous discard of buffered and in-flight words
m_valid_o  out  1  stream valid
m_data_o  out  DATA_WIDTH  stream data
m_ready_i  in  1  stream ready
err_o  out  1  sticky error flag
cnt_o  out  CNT_WIDTH  words delivered (valid && ready)

Behaviour:
- Reset state: m_valid_o=0, m_data_o=0, err_o=0, cnt_o=0, occupancy=0, in-flight=0, buffer pointers=0. fifo_ren_o=0 during reset, because occupancy and in-flight are 0 and the FIFO holds empty=1.
- fifo_ren_o = !fifo_empty_i && !flush_i && (occ_r + infl_r < BUF_DEPTH).
  - Both occ_r and infl_r are registered, so m_ready_i has no combinational path to fifo_ren_o.
  - fifo_ren_o is never asserted while fifo_empty_i=1, so the FIFO never raises rerr because of this block.
- In-flight tracking:
  - RDATA_REG=1: infl_r (0/1) <= fifo_ren_o. The word in fifo_rdata_i is written into the buffer on the cycle after ren while infl_r=1.
  - RDATA_REG=0: infl_r stays 0. fifo_rdata_i is written into the buffer in the same cycle as fifo_ren_o.
- Buffer: circular buffer of BUF_DEPTH entries with write/read pointers that wrap modulo BUF_DEPTH (non-power-of-2 handled). occ_r is 0..BUF_DEPTH.
  - Push and pop in the same cycle leave occ_r unchanged.
  - Overflow cannot occur by construction; the bench checks this with an assertion.
- Output: m_valid_o = (occ_r != 0). m_data_o is the head entry, registered-out. Data is stable while m_valid_o && !m_ready_i.
  - Latency with an empty buffer: first word is valid 2 cycles after fifo_ren_o (RDATA_REG=1) or 1 cycle after (RDATA_REG=0).
  - Throughput: 1 word/cycle sustained when BUF_DEPTH >= 2 + RDATA_REG.
- Flush (flush_i=1 for one cycle):
  - Next cycle: occ_r=0 and m_valid_o=0.
  - A word in flight (infl_r=1) during the flush cycle is dropped.
  - fifo_ren_o=0 during the flush cycle.
  - FIFO words already read are lost; this is intended.
  - cnt_o does not count a handshake that coincides with flush.
  - err_o is cleared by flush.
- err_o: set on fifo_rerr_i=1, or on a push attempt with occ_r==BUF_DEPTH and no pop. Held until reset or flush.
- cnt_o: increments on m_valid_o && m_ready_i; wraps from all-ones to 0.
- fifo_empty_i deasserting and reasserting between words causes gaps only; no data is duplicated or skipped.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam functions for buffer pointer width, clog2(BUF_DEPTH);
  - the legal BUF_DEPTH range constants.
- One sub-module, stream_ring_buf: parameterised circular buffer with push/pop/flush, occ output and head data.
- The adapter top holds ren/in-flight control, error, counter and parameter checks.

Test Plan:
- Reset, FIFO empty, ready=1 -> fifo_ren_o=0, m_valid_o=0, cnt_o=0, err_o=0 for 20 cycles.
- RDATA_REG=1, FIFO preloaded with 0x0..0xF, ready=1 -> first m_valid_o 2 cycles after first ren; 16 words in order on 16 consecutive cycles; cnt_o=16.
- Same 16 words, ready held 0 -> exactly BUF_DEPTH=3 reads issued, m_data_o=0x0 held stable. Then ready=1 -> 0x0..0xF with no loss or duplication.
- Ready toggled 1/0 each cycle, RDATA_REG=0 -> all words 0x0..0xF delivered in order; occ_r never exceeds 3.
- Flush asserted with 2 words buffered and 1 in flight -> m_valid_o=0 next cycle, in-flight word dropped, next delivered word is the following FIFO entry, cnt_o unchanged.
- fifo_rerr_i pulsed once -> err_o=1 next cycle and held; flush -> err_o=0.
